mult_result_reader: RTL and testbench

Avalon-MM read master that drains multiplier results from a result RAM's 32-bit Avalon slave window. Each product is reassembled from several 32-bit words into one wide word. Products leave on a valid/ready stream toward the checker/host-side logic. Sits opposite the result RAM slave port: this block is the initiator of the reads that port serves.

---
 rtl/mult_result_reader_pkg.sv | 24 ++
 rtl/mult_result_reader_if.sv | 26 ++
 rtl/mult_result_reader_latency_shift.sv | 24 ++
 rtl/mult_result_reader.sv | 120 ++++++++++++
 tb/tb_mult_result_reader.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_result_reader_pkg.sv
// Shared types and constants for the multiplier result reader.
package mult_result_reader_pkg;
  localparam int AV_DATA_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int WORDS          = DEF_DATA_WIDTH / AV_DATA_WIDTH;
  localparam int WORD_SEL_WIDTH = $clog2(WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_e;

  function automatic int words_of(input int data_width);
    return data_width / AV_DATA_WIDTH;
  endfunction

  // A one-word product still needs a 1-bit selector
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mult_result_reader_if.sv
// Avalon-MM read side plus product stream; master = reader, slave = RAM/sink side.
interface mult_result_reader_if
  import mult_result_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = 128,
  parameter int AV_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH   = 9
);
  logic                     av_read;
  logic [AV_ADDR_WIDTH-1:0] av_address;
  logic [AV_DATA_WIDTH-1:0] av_readdata;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [COUNT_WIDTH-1:0]   out_index;

  modport master (
    output av_read, av_address, out_data, out_valid, out_index,
    input  av_readdata, out_ready
  );

  modport slave (
    input  av_read, av_address, out_data, out_valid, out_index,
    output av_readdata, out_ready
  );
endinterface

// File: rtl/mult_result_reader_latency_shift.sv
// Delays the read strobe by the fixed RAM latency to mark the readdata capture cycle.
module mult_result_reader_latency_shift #(
  parameter int LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic flush_i,
  input  logic strobe_i,
  output logic cap_en_o
);
  logic [LATENCY:0] vld_pipe;
  logic [LATENCY:1] pipe_q;

  assign vld_pipe = {pipe_q, strobe_i};

  // Flushing on abort keeps a stale strobe from landing in a later transfer's WAIT
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        pipe_q <= '0;
    else if (flush_i) pipe_q <= '0;
    else              pipe_q <= vld_pipe[LATENCY-1:0];
  end

  assign cap_en_o = vld_pipe[LATENCY];
endmodule

// File: rtl/mult_result_reader.sv
// Avalon-MM read master: fetches WORDS 32-bit words per product and streams them out.
module mult_result_reader
  import mult_result_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int AV_ADDR_WIDTH = 5,
  parameter int READ_LATENCY  = 1,
  parameter int COUNT_WIDTH   = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [COUNT_WIDTH-1:0] base_index_i,
  input  logic [COUNT_WIDTH-1:0] num_products_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  mult_result_reader_if.master   bus
);
  localparam int NW  = words_of(DATA_WIDTH);
  localparam int SW  = sel_width(NW);
  localparam int AFW = COUNT_WIDTH + SW;

  state_e                               state_q, state_d;
  logic [COUNT_WIDTH-1:0]               k_q, k_d;
  logic [COUNT_WIDTH-1:0]               rem_q, rem_d;
  logic [SW-1:0]                        w_q, w_d;
  logic [NW-1:0][AV_DATA_WIDTH-1:0]     data_q, data_d;
  logic                                 rd;
  logic                                 cap_en;
  logic                                 hs;
  logic [AFW-1:0]                       addr_full;

  mult_result_reader_latency_shift #(.LATENCY(READ_LATENCY)) u_lat (
    .clock    (clock),
    .reset    (reset),
    .flush_i  (abort_i && (state_q != S_IDLE)),
    .strobe_i (rd),
    .cap_en_o (cap_en)
  );

  assign hs = (state_q == S_PRESENT) && bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      rem_q   <= '0;
      w_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
      w_q     <= w_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rem_d   = rem_q;
    w_d     = w_q;
    data_d  = data_q;
    rd      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          k_d     = base_index_i;
          rem_d   = num_products_i;
          w_d     = '0;
          state_d = (num_products_i == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort_i) state_d = S_DONE;
        else begin
          rd      = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort_i) state_d = S_DONE;
        else if (cap_en) begin
          data_d[w_q] = bus.av_readdata;
          if (w_q == SW'(NW - 1)) state_d = S_PRESENT;
          else begin
            w_d     = w_q + SW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_PRESENT: begin
        // A handshake coinciding with abort still consumes the product
        if (hs) begin
          rem_d = rem_q - COUNT_WIDTH'(1);
          if (abort_i || rem_q == COUNT_WIDTH'(1)) state_d = S_DONE;
          else begin
            k_d     = k_q + COUNT_WIDTH'(1);
            w_d     = '0;
            state_d = S_ISSUE;
          end
        end else if (abort_i) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address is formed wide then truncated, so window wrap-around is silent
  assign addr_full      = AFW'(k_q) * AFW'(NW) + AFW'(w_q);
  assign bus.av_address = addr_full[AV_ADDR_WIDTH-1:0];
  assign bus.av_read    = rd;
  assign bus.out_valid  = (state_q == S_PRESENT);
  assign bus.out_data   = data_q;
  assign bus.out_index  = k_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
endmodule

// File: tb/tb_mult_result_reader.sv
// Randomized + directed bench for mult_result_reader against a queue-based product model.
module tb_mult_result_reader;
  import mult_result_reader_pkg::*;
  localparam int DW = 128, AW = 5, CW = 9, LAT_A = 1, LAT_B = 3;
  typedef logic [DW-1:0] wide_t;
  typedef struct { int idx; wide_t data; } prod_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_a = 1'b0, rst_b = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [CW-1:0] base_a = '0, num_a = '0, base_b = '0, num_b = '0;
  logic busy_a, done_a, busy_b, done_b;

  mult_result_reader_if #(.DATA_WIDTH(DW), .AV_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) ifa ();
  mult_result_reader_if #(.DATA_WIDTH(DW), .AV_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) ifb ();

  mult_result_reader #(.DATA_WIDTH(DW), .AV_ADDR_WIDTH(AW), .READ_LATENCY(LAT_A), .COUNT_WIDTH(CW)) u_a (
    .clock(clock), .reset(rst_a), .start_i(start_a), .base_index_i(base_a), .num_products_i(num_a),
    .abort_i(abort_a), .busy_o(busy_a), .done_o(done_a), .bus(ifa.master));
  mult_result_reader #(.DATA_WIDTH(DW), .AV_ADDR_WIDTH(AW), .READ_LATENCY(LAT_B), .COUNT_WIDTH(CW)) u_b (
    .clock(clock), .reset(rst_b), .start_i(start_b), .base_index_i(base_b), .num_products_i(num_b),
    .abort_i(abort_b), .busy_o(busy_b), .done_o(done_b), .bus(ifb.master));

  int tests = 0, fails = 0;

  task automatic check(input string nm, input wide_t act, input wide_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memw(input int a);
    return 32'hA000_0000 + 32'(a % 32);
  endfunction

  function automatic wide_t prod(input int k);
    wide_t r;
    for (int w = 0; w < 4; w++) r[32*w +: 32] = memw(k * 4 + w);
    return r;
  endfunction

  // RAM models: data is correct only in the exact latency cycle, garbage otherwise
  logic [4:1]         rva = '0, rvb = '0;
  logic [4:1][AW-1:0] raa = '0, rab = '0;
  always @(posedge clock) begin
    rva <= {rva[3:1], ifa.av_read};
    raa <= {raa[3:1], ifa.av_address};
    rvb <= {rvb[3:1], ifb.av_read};
    rab <= {rab[3:1], ifb.av_address};
  end
  assign ifa.av_readdata = rva[LAT_A] ? memw(int'(raa[LAT_A])) : 32'hDEAD_BEEF;
  assign ifb.av_readdata = rvb[LAT_B] ? memw(int'(rab[LAT_B])) : 32'hDEAD_BEEF;

  // ---- model + compare for instance A ----
  int cyc_a = 0, m_done_at = -1, last_rd = -100;
  bit m_busy = 0, pv = 0, pabort = 0;
  wide_t pdata;
  logic [CW-1:0] pidx;
  prod_t exp_q[$];
  int exp_addr[$];
  wide_t hs_data_log[$];
  int hs_idx_log[$], hs_cyc_log[$], rd_addr_log[$];
  int rd_cnt = 0, done_cnt = 0, done_cyc = -1, busy_cnt = 0, valid_cnt = 0;

  always @(negedge clock) begin : cmp_a
    bit mb;
    int k;
    mb = m_busy;
    if (!rst_a) begin
      check("busy", wide_t'(busy_a), wide_t'(mb));
      if (busy_a) busy_cnt++;
      if (ifa.av_read) begin
        rd_cnt++;
        rd_addr_log.push_back(int'(ifa.av_address));
        if (exp_addr.size() == 0) check("read_expected", 1, 0);
        else check("rd_addr", wide_t'(ifa.av_address), wide_t'(exp_addr.pop_front()));
        check("rd_one_outstanding", wide_t'(cyc_a - last_rd >= 1 + LAT_A), 1);
        last_rd = cyc_a;
      end
      if (pv && !pabort) begin
        check("hold_valid", wide_t'(ifa.out_valid), 1);
        check("hold_data", ifa.out_data, pdata);
        check("hold_index", wide_t'(ifa.out_index), wide_t'(pidx));
      end
      if (ifa.out_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) check("valid_expected", 1, 0);
        else begin
          check("out_data", ifa.out_data, exp_q[0].data);
          check("out_index", wide_t'(ifa.out_index), wide_t'(exp_q[0].idx));
        end
        if (ifa.out_ready) begin
          hs_data_log.push_back(ifa.out_data);
          hs_idx_log.push_back(int'(ifa.out_index));
          hs_cyc_log.push_back(cyc_a);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_done_at = cyc_a + 1;
        end
      end
      if (start_a && !mb) begin
        m_busy = 1;
        for (int i = 0; i < int'(num_a); i++) begin
          k = (int'(base_a) + i) % 512;
          exp_q.push_back('{k, prod(k)});
          for (int w = 0; w < 4; w++) exp_addr.push_back((k * 4 + w) % 32);
        end
        if (num_a == '0) m_done_at = cyc_a + 1;
      end
      if (abort_a && mb && !done_a) begin
        exp_q.delete();
        exp_addr.delete();
        m_done_at = cyc_a + 1;
      end
      if (done_a) begin
        done_cnt++;
        done_cyc = cyc_a;
        check("done_timing", wide_t'(cyc_a), wide_t'(m_done_at));
        m_busy = 0;
        m_done_at = -1;
      end else if (m_done_at == cyc_a) check("done_missing", 0, 1);
      pv = ifa.out_valid && !ifa.out_ready;
      pdata = ifa.out_data;
      pidx = ifa.out_index;
      pabort = abort_a;
    end
    cyc_a++;
  end

  // ---- logging for instance B ----
  int cyc_b = 0, busyb_cnt = 0, doneb_cnt = 0;
  int rdb_cyc[$], hsb_idx[$];
  wide_t hsb_data[$];
  always @(negedge clock) begin
    if (ifb.av_read) rdb_cyc.push_back(cyc_b);
    if (ifb.out_valid && ifb.out_ready) begin
      hsb_data.push_back(ifb.out_data);
      hsb_idx.push_back(int'(ifb.out_index));
    end
    if (busy_b) busyb_cnt++;
    if (done_b) doneb_cnt++;
    cyc_b++;
  end

  function automatic wide_t hs_at(input int i);
    return (i < hs_data_log.size()) ? hs_data_log[i] : '0;
  endfunction
  function automatic int ia(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic go_a(input int b, input int n);
    @(posedge clock); #1;
    start_a = 1'b1; base_a = CW'(b); num_a = CW'(n);
    @(posedge clock); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int maxc, input bit rnd);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < maxc) begin
      @(posedge clock); #1;
      if (rnd) ifa.out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (done_cnt == d0) check("done_timeout_a", 0, 1);
    ifa.out_ready = 1'b1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0, r0, b0, v0, d0, n;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    #2 rst_a = 1'b1; rst_b = 1'b1;
    #1;
    check("rst_busy", wide_t'(busy_a), 0);
    check("rst_done", wide_t'(done_a), 0);
    check("rst_av_read", wide_t'(ifa.av_read), 0);
    check("rst_av_address", wide_t'(ifa.av_address), 0);
    check("rst_out_valid", wide_t'(ifa.out_valid), 0);
    check("rst_out_data", ifa.out_data, 0);
    check("rst_out_index", wide_t'(ifa.out_index), 0);
    repeat (3) @(posedge clock);
    #1 rst_a = 1'b0; rst_b = 1'b0;

    // base 0, two products
    n0 = hs_data_log.size(); r0 = rd_cnt;
    go_a(0, 2); wait_done_a(100, 0);
    check("t1_hs_count", wide_t'(hs_data_log.size() - n0), 2);
    check("t1_prod0", hs_at(n0), 128'hA0000003_A0000002_A0000001_A0000000);
    check("t1_prod1", hs_at(n0 + 1), 128'hA0000007_A0000006_A0000005_A0000004);
    check("t1_idx0", wide_t'(ia(hs_idx_log, n0)), 0);
    check("t1_idx1", wide_t'(ia(hs_idx_log, n0 + 1)), 1);
    check("t1_reads", wide_t'(rd_cnt - r0), 8);
    check("t1_done_after_hs", wide_t'(done_cyc - ia(hs_cyc_log, n0 + 1)), 1);

    // address window wrap
    n0 = hs_data_log.size(); r0 = rd_addr_log.size();
    go_a(7, 2); wait_done_a(100, 0);
    check("t2_addr_first", wide_t'(ia(rd_addr_log, r0)), 28);
    check("t2_addr_p7_last", wide_t'(ia(rd_addr_log, r0 + 3)), 31);
    check("t2_addr_wrap", wide_t'(ia(rd_addr_log, r0 + 4)), 0);
    check("t2_addr_last", wide_t'(ia(rd_addr_log, r0 + 7)), 3);
    check("t2_prod7", hs_at(n0), 128'hA000001F_A000001E_A000001D_A000001C);
    check("t2_prod8", hs_at(n0 + 1), 128'hA0000003_A0000002_A0000001_A0000000);
    check("t2_idx8", wide_t'(ia(hs_idx_log, n0 + 1)), 8);

    // zero products
    r0 = rd_cnt; b0 = busy_cnt; v0 = valid_cnt; d0 = done_cnt;
    go_a(5, 0);
    repeat (5) @(posedge clock);
    check("t3_busy_cycles", wide_t'(busy_cnt - b0), 1);
    check("t3_done_pulses", wide_t'(done_cnt - d0), 1);
    check("t3_reads", wide_t'(rd_cnt - r0), 0);
    check("t3_valids", wide_t'(valid_cnt - v0), 0);

    // backpressure for 10 cycles
    ifa.out_ready = 1'b0;
    go_a(2, 2);
    n = 0;
    while (!ifa.out_valid && n < 100) begin @(negedge clock); n++; end
    check("t4_valid_seen", wide_t'(ifa.out_valid), 1);
    pdata_snap: begin
      wide_t d;
      d = ifa.out_data; r0 = rd_cnt;
      repeat (10) @(negedge clock);
      check("t4_valid_held", wide_t'(ifa.out_valid), 1);
      check("t4_data_held", ifa.out_data, d);
      check("t4_data_val", d, 128'hA000000B_A000000A_A0000009_A0000008);
      check("t4_no_reads", wide_t'(rd_cnt - r0), 0);
    end
    @(posedge clock); #1 ifa.out_ready = 1'b1;
    @(negedge clock);
    check("t4_handshake", wide_t'(ifa.out_valid), 1);
    @(negedge clock);
    check("t4_next_read", wide_t'(ifa.av_read), 1);
    check("t4_next_addr", wide_t'(ifa.av_address), 12);
    wait_done_a(100, 0);

    // abort in WAIT of product 0 word 2
    r0 = rd_cnt; v0 = valid_cnt;
    go_a(0, 3);
    n = 0;
    while (rd_cnt - r0 < 3 && n < 100) begin @(posedge clock); n++; end
    #1 abort_a = 1'b1;
    @(posedge clock); #1 abort_a = 1'b0;
    @(negedge clock);
    check("t5_done", wide_t'(done_a), 1);
    repeat (6) @(posedge clock);
    check("t5_reads", wide_t'(rd_cnt - r0), 3);
    check("t5_no_valid", wide_t'(valid_cnt - v0), 0);
    n0 = hs_data_log.size();
    go_a(5, 1); wait_done_a(100, 0);
    check("t5_after_prod", hs_at(n0), 128'hA0000017_A0000016_A0000015_A0000014);

    // randomized transfers, with stray starts and occasional aborts
    for (int t = 0; t < 14; t++) begin
      go_a(int'($urandom_range(0, 511)), int'($urandom_range(1, 4)));
      repeat (3) @(posedge clock);
      #1 start_a = 1'b1; base_a = CW'($urandom); num_a = CW'($urandom);
      @(posedge clock); #1 start_a = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 25)) @(posedge clock);
        #1 abort_a = 1'b1;
        @(posedge clock); #1 abort_a = 1'b0;
        if (busy_a) wait_done_a(20, 0);
      end else wait_done_a(400, 1);
      repeat (2) @(posedge clock);
    end

    // READ_LATENCY=3 instance: async reset mid-WAIT, then a clean transfer
    @(posedge clock); #1 start_b = 1'b1; base_b = '0; num_b = CW'(2);
    @(posedge clock); #1 start_b = 1'b0;
    n = 0;
    while (rdb_cyc.size() < 6 && n < 200) begin @(posedge clock); n++; end
    #1;
    check("b_pre_index", wide_t'(ifb.out_index), 1);
    check("b_prod0_lat3", (hsb_data.size() > 0) ? hsb_data[0] : '0,
          128'hA0000003_A0000002_A0000001_A0000000);
    #1 rst_b = 1'b1;
    #1;
    check("b_rst_busy", wide_t'(busy_b), 0);
    check("b_rst_done", wide_t'(done_b), 0);
    check("b_rst_av_read", wide_t'(ifb.av_read), 0);
    check("b_rst_av_address", wide_t'(ifb.av_address), 0);
    check("b_rst_out_valid", wide_t'(ifb.out_valid), 0);
    check("b_rst_out_data", ifb.out_data, 0);
    check("b_rst_out_index", wide_t'(ifb.out_index), 0);
    @(posedge clock); @(posedge clock); #3 rst_b = 1'b0;
    r0 = rdb_cyc.size(); b0 = busyb_cnt;
    repeat (8) @(posedge clock);
    check("b_idle_reads", wide_t'(rdb_cyc.size() - r0), 0);
    check("b_idle_busy", wide_t'(busyb_cnt - b0), 0);
    n0 = hsb_data.size(); d0 = doneb_cnt;
    @(posedge clock); #1 start_b = 1'b1; base_b = CW'(3); num_b = CW'(2);
    @(posedge clock); #1 start_b = 1'b0;
    n = 0;
    while (doneb_cnt == d0 && n < 200) begin @(posedge clock); n++; end
    check("b_done", wide_t'(doneb_cnt - d0), 1);
    check("b_reads", wide_t'(rdb_cyc.size() - r0), 8);
    check("b_prod3", (hsb_data.size() > n0) ? hsb_data[n0] : '0,
          128'hA000000F_A000000E_A000000D_A000000C);
    check("b_prod4", (hsb_data.size() > n0 + 1) ? hsb_data[n0 + 1] : '0, prod(4));
    check("b_idx4", wide_t'(ia(hsb_idx, n0 + 1)), 4);
    for (int i = 0; i < 7; i++)
      if (i != 3)
        check("b_word_gap", wide_t'(ia(rdb_cyc, r0 + i + 1) - ia(rdb_cyc, r0 + i)), 1 + LAT_B);
    check("b_product_gap", wide_t'(ia(rdb_cyc, r0 + 4) - ia(rdb_cyc, r0 + 3)), 2 + LAT_B);

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
